// File: rtl/plugboard_cfg.sv
// Runtime-programmable Enigma plugboard: involutive swap table, registered key lookup, press counter.
// Define PLUGBOARD_REV_EN to add a return-path lookup port sharing the same table.
module plugboard_cfg #(
    parameter int unsigned ALPHA     = 26,
    parameter int unsigned W         = 5,
    parameter int unsigned MAX_PAIRS = 13,
    parameter int unsigned CNT_W     = 16,
    localparam int unsigned PW       = $clog2(MAX_PAIRS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_op,
    input  logic [W-1:0]     cfg_a,
    input  logic [W-1:0]     cfg_b,
    output logic             cfg_done,
    output logic             cfg_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_char,
    output logic             out_valid,
    output logic [W-1:0]     out_char,
    output logic             out_err,
`ifdef PLUGBOARD_REV_EN
    input  logic             rev_valid,
    input  logic [W-1:0]     rev_char,
    output logic             rev_ready,
    output logic             rev_out_valid,
    output logic [W-1:0]     rev_out_char,
`endif
    output logic [CNT_W-1:0] press_count,
    output logic [PW-1:0]    pair_count
);

    localparam logic [W:0]    ALPHA_X  = (W + 1)'(ALPHA);
    localparam logic [W-1:0]  LAST_IDX = W'(ALPHA - 1);
    localparam logic [PW-1:0] MAX_P    = PW'(MAX_PAIRS);
    localparam logic [1:0]    OP_CONN  = 2'd0;
    localparam logic [1:0]    OP_DISC  = 2'd1;
    localparam logic [1:0]    OP_CLEAR = 2'd2;

    typedef enum logic [2:0] {StIdle, StCheck, StReject, StWrite, StClear} state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       map_q [ALPHA];
    logic [1:0]         op_q;
    logic [W-1:0]       a_q, b_q;
    logic [W-1:0]       clr_idx_q, clr_idx_d;
    logic [PW-1:0]      pair_q, pair_d;
    logic               done_q, done_d, err_q, err_d;
    logic [CNT_W-1:0]   press_q;
    logic               out_valid_q, out_err_q;
    logic [W-1:0]       out_char_q;

    function automatic logic in_range(input logic [W-1:0] c);
        return {1'b0, c} < ALPHA_X;
    endfunction

    logic         idle, key_acc, a_ok, b_ok, conn_ok, disc_ok;
    logic [W-1:0] map_a, map_b;

    assign idle    = (state_q == StIdle);
    assign key_acc = in_valid && idle;
    assign a_ok    = in_range(a_q);
    assign b_ok    = in_range(b_q);
    assign map_a   = map_q[a_q];
    assign map_b   = map_q[b_q];
    assign conn_ok = a_ok && b_ok && (a_q != b_q) && (map_a == a_q) && (map_b == b_q)
                     && (pair_q != MAX_P);
    assign disc_ok = a_ok && (map_a != a_q);

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        pair_d    = pair_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cfg_valid) state_d = StCheck;
            end
            StCheck: begin
                unique case (op_q)
                    OP_CONN:  state_d = conn_ok ? StWrite : StReject;
                    OP_DISC:  state_d = disc_ok ? StWrite : StReject;
                    OP_CLEAR: begin
                        state_d   = StClear;
                        clr_idx_d = '0;
                    end
                    default:  state_d = StReject;
                endcase
            end
            // Extra cycle keeps rejection latency equal to the write path.
            StReject: begin
                done_d  = 1'b1;
                err_d   = 1'b1;
                state_d = StIdle;
            end
            StWrite: begin
                done_d  = 1'b1;
                pair_d  = (op_q == OP_CONN) ? pair_q + PW'(1) : pair_q - PW'(1);
                state_d = StIdle;
            end
            StClear: begin
                clr_idx_d = clr_idx_q + W'(1);
                if (clr_idx_q == LAST_IDX) begin
                    pair_d  = '0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            clr_idx_q <= '0;
            pair_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            pair_q    <= pair_d;
            done_q    <= done_d;
            err_q     <= err_d;
            if (cfg_valid && idle) begin
                op_q <= cfg_op;
                a_q  <= cfg_a;
                b_q  <= cfg_b;
            end
        end
    end

    // Table writes; the table is only read for keys while idle, so the sweep is never observed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ALPHA); i++) map_q[i] <= W'(i);
        end else if (state_q == StWrite) begin
            if (op_q == OP_CONN) begin
                map_q[a_q] <= b_q;
                map_q[b_q] <= a_q;
            end else begin
                map_q[a_q]   <= a_q;
                map_q[map_a] <= map_a;
            end
        end else if (state_q == StClear) begin
            map_q[clr_idx_q] <= clr_idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_char_q  <= '0;
            out_err_q   <= 1'b0;
            press_q     <= '0;
        end else begin
            out_valid_q <= key_acc;
            if (key_acc) begin
                out_char_q <= in_range(in_char) ? map_q[in_char] : '0;
                out_err_q  <= !in_range(in_char);
                press_q    <= press_q + CNT_W'(1);
            end
        end
    end

`ifdef PLUGBOARD_REV_EN
    logic         rev_acc, rev_out_valid_q;
    logic [W-1:0] rev_out_char_q;

    assign rev_acc = rev_valid && idle;

    always_ff @(posedge clk) begin
        if (rst) begin
            rev_out_valid_q <= 1'b0;
            rev_out_char_q  <= '0;
        end else begin
            rev_out_valid_q <= rev_acc;
            if (rev_acc) rev_out_char_q <= in_range(rev_char) ? map_q[rev_char] : '0;
        end
    end

    assign rev_ready     = idle;
    assign rev_out_valid = rev_out_valid_q;
    assign rev_out_char  = rev_out_char_q;
`endif

    assign cfg_ready   = idle;
    assign in_ready    = idle;
    assign cfg_done    = done_q;
    assign cfg_err     = err_q;
    assign out_valid   = out_valid_q;
    assign out_char    = out_char_q;
    assign out_err     = out_err_q;
    assign press_count = press_q;
    assign pair_count  = pair_q;

endmodule

// File: tb/tb_plugboard_cfg.sv
// Self-checking bench for plugboard_cfg: table-driven config vectors, key scoreboard,
// hand-written sequences for stall, same-cycle and mid-clear reset.
module tb_plugboard_cfg;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid, cfg_ready, cfg_done, cfg_err;
    logic [1:0]  cfg_op;
    logic [4:0]  cfg_a, cfg_b;
    logic        in_valid, in_ready, out_valid, out_err;
    logic [4:0]  in_char, out_char;
    logic [15:0] press_count;
    logic [3:0]  pair_count;

    plugboard_cfg dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_op     (cfg_op),
        .cfg_a      (cfg_a),
        .cfg_b      (cfg_b),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .out_valid  (out_valid),
        .out_char   (out_char),
        .out_err    (out_err),
        .press_count(press_count),
        .pair_count (pair_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] ch;
        logic       err;
    } exp_t;

    typedef struct {
        logic [1:0] op;
        logic [4:0] a;
        logic [4:0] b;
        logic       err;
    } cfg_vec_t;

    exp_t       sb[$];
    cfg_vec_t   vecs[9];
    logic [4:0] model[26];
    int         m_pairs, m_press;
    int         total = 0, bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 26; i++) model[i] = 5'(i);
        m_pairs = 0;
    endtask

    function automatic exp_t lookup(input logic [4:0] c);
        exp_t e;
        if (c >= 5'd26) begin
            e.ch = 5'd0; e.err = 1'b1;
        end else begin
            e.ch = model[c]; e.err = 1'b0;
        end
        return e;
    endfunction

    task automatic check_out(input string tag);
        exp_t e;
        check({tag, " out_valid"}, int'(out_valid), 1);
        if (out_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " out_char"}, int'(out_char), int'(e.ch));
            check({tag, " out_err"}, int'(out_err), int'(e.err));
        end
    endtask

    // Called at a negedge; presents key, waits for acceptance, checks the translated output.
    task automatic press(input logic [4:0] c, input string tag);
        int k;
        in_valid = 1'b1;
        in_char  = c;
        k = 0;
        while (!in_ready && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            check({tag, " in_ready timeout"}, 0, 1);
            in_valid = 1'b0;
            return;
        end
        sb.push_back(lookup(c));
        m_press++;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check_out(tag);
    endtask

    task automatic model_apply(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b);
        logic [4:0] p;
        case (op)
            2'd0: begin model[a] = b; model[b] = a; m_pairs++; end
            2'd1: begin p = model[a]; model[a] = a; model[p] = p; m_pairs--; end
            2'd2: model_reset();
            default: ;
        endcase
    endtask

    // Called at a negedge; latency counted in clock edges after acceptance.
    task automatic do_cfg(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                          input logic exp_err, input int exp_lat, input string tag);
        int k;
        cfg_valid = 1'b1;
        cfg_op = op; cfg_a = a; cfg_b = b;
        k = 0;
        while (!cfg_ready && k < 60) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        @(negedge clk);
        k = 0;
        while (!cfg_done && k < 60) begin
            @(negedge clk);
            k++;
        end
        check({tag, " latency"}, k, exp_lat);
        check({tag, " cfg_err"}, int'(cfg_err), int'(exp_err));
        check({tag, " ready with done"}, int'(cfg_ready), 1);
        if (cfg_done && !exp_err) model_apply(op, a, b);
        check({tag, " pair_count"}, int'(pair_count), m_pairs);
    endtask

    initial begin
        int k, lowcnt, donecnt, early;
        int free_l[$];
        exp_t e;

        vecs[0] = '{op: 2'd0, a: 5'd0,  b: 5'd4,  err: 1'b0};
        vecs[1] = '{op: 2'd0, a: 5'd1,  b: 5'd23, err: 1'b0};
        vecs[2] = '{op: 2'd0, a: 5'd4,  b: 5'd9,  err: 1'b1};
        vecs[3] = '{op: 2'd0, a: 5'd3,  b: 5'd3,  err: 1'b1};
        vecs[4] = '{op: 2'd0, a: 5'd26, b: 5'd2,  err: 1'b1};
        vecs[5] = '{op: 2'd3, a: 5'd7,  b: 5'd8,  err: 1'b1};
        vecs[6] = '{op: 2'd1, a: 5'd4,  b: 5'd0,  err: 1'b0};
        vecs[7] = '{op: 2'd1, a: 5'd4,  b: 5'd0,  err: 1'b1};
        vecs[8] = '{op: 2'd1, a: 5'd30, b: 5'd0,  err: 1'b1};

        rst = 1'b1; cfg_valid = 1'b0; cfg_op = '0; cfg_a = '0; cfg_b = '0;
        in_valid = 1'b0; in_char = '0;
        model_reset();
        m_press = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst cfg_ready", int'(cfg_ready), 1);
        check("rst in_ready", int'(in_ready), 1);
        check("rst cfg_done", int'(cfg_done), 0);
        check("rst cfg_err", int'(cfg_err), 0);
        check("rst out_valid", int'(out_valid), 0);
        check("rst out_char", int'(out_char), 0);
        check("rst out_err", int'(out_err), 0);
        check("rst press_count", int'(press_count), 0);
        check("rst pair_count", int'(pair_count), 0);

        for (int c = 0; c < 26; c++) press(5'(c), $sformatf("ident%0d", c));
        check("press after 26", int'(press_count), 26);

        for (int i = 0; i < 9; i++) begin
            do_cfg(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].err, 2, $sformatf("vec%0d", i));
            press(vecs[i].a, $sformatf("vec%0d key a", i));
            press(vecs[i].b, $sformatf("vec%0d key b", i));
        end
        press(5'd0, "k0");
        press(5'd23, "k23");
        press(5'd2, "k2");

        for (int c = 0; c < 26; c++) if (model[c] == 5'(c)) free_l.push_back(c);
        for (int p = 0; p + 1 < free_l.size(); p += 2)
            do_cfg(2'd0, 5'(free_l[p]), 5'(free_l[p+1]), 1'b0, 2, $sformatf("fill%0d", p));
        check("full pair_count", int'(pair_count), 13);
        do_cfg(2'd0, 5'd0, 5'd2, 1'b1, 2, "max pairs");
        for (int c = 0; c < 26; c += 5) press(5'(c), $sformatf("full key%0d", c));

        // Clear with a key held from the cycle after acceptance; key must stall, not drop.
        cfg_valid = 1'b1; cfg_op = 2'd2;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        in_valid = 1'b1; in_char = 5'd1;
        @(negedge clk);
        k = 0; lowcnt = 0; early = 0;
        while (!cfg_done && k < 60) begin
            if (!in_ready) lowcnt++;
            if (out_valid) early++;
            @(negedge clk);
            k++;
        end
        check("clear latency", k, 27);
        check("clear stall cycles", lowcnt, 27);
        check("clear early out", early, 0);
        check("clear err", int'(cfg_err), 0);
        check("clear pair_count", int'(pair_count), 0);
        model_reset();
        sb.push_back(lookup(5'd1));
        m_press++;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check_out("stalled key");

        // Same-cycle config and key: key uses the table before the connect.
        cfg_valid = 1'b1; cfg_op = 2'd0; cfg_a = 5'd5; cfg_b = 5'd6;
        in_valid = 1'b1; in_char = 5'd5;
        sb.push_back(lookup(5'd5));
        m_press++;
        @(posedge clk);
        #1 cfg_valid = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_out("same-cycle key");
        k = 0;
        while (!cfg_done && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("same-cycle cfg latency", k, 2);
        if (cfg_done && !cfg_err) model_apply(2'd0, 5'd5, 5'd6);
        press(5'd5, "after same-cycle");

        press(5'd30, "key30");
        check("press_count", int'(press_count), m_press);

        // Reset in the middle of a clear sweep.
        cfg_valid = 1'b1; cfg_op = 2'd2;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        donecnt = 0; early = 0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (cfg_done) donecnt++;
            if (out_valid) early++;
        end
        check("rst abort done", donecnt, 0);
        check("rst abort out_valid", early, 0);
        check("rst abort press", int'(press_count), 0);
        check("rst abort pairs", int'(pair_count), 0);
        check("rst abort ready", int'(cfg_ready), 1);
        model_reset();
        m_press = 0;
        press(5'd5, "post-rst key5");
        press(5'd6, "post-rst key6");
        check("post-rst press", int'(press_count), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
